wb_line_responder: RTL and testbench

- Wishbone slave: the responder end of the 128-bit line interface that the L2 cache and cache interconnect drive as master toward physical memory.
- Backs the interface with an internal line-wide storage array.
- Adds programmable access latency, byte-lane write masking and out-of-range retry.
- Serves as the synthesizable physical-memory stand-in for top-level integration and as a slave for cache unit benches.

---
 rtl/wb_line_responder_if.sv | 26 ++
 rtl/wb_line_responder.sv | 140 ++++++++++++++
 tb/tb_wb_line_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_line_responder_if.sv
// 128-bit Wishbone line bus between a cache-side master and a line-wide memory slave.
// Carries one request (CYC/STB/WE/ADR/SEL/DAT_M) and its single-cycle reply (DAT_S/ACK/RTY).
// No buffering: the slave holds off simply by not asserting ACK/RTY yet.
interface wb_line_responder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  CYC;
    logic                  STB;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] ADR;
    logic [15:0]           SEL;
    logic [127:0]          DAT_M;
    logic [127:0]          DAT_S;
    logic                  ACK;
    logic                  RTY;

    modport master (
        output CYC, STB, WE, ADR, SEL, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CYC, STB, WE, ADR, SEL, DAT_M,
        output DAT_S, ACK, RTY
    );
endinterface

// File: rtl/wb_line_responder.sv
// Wishbone line slave backed by a 128-bit-wide array; byte-lane writes, retry on out-of-range lines.
// Latency: ACK/RTY is high in the cycle after edge N+LATENCY-1 for a request accepted at edge N.
// Backpressure: one transaction at a time; the master waits for ACK/RTY, dropping CYC/STB aborts.
module wb_line_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    wb_line_responder_if.slave bus
);

    localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [15:0]           r_sel;
    logic [127:0]          r_dat;
    logic [127:0]          r_dat_s;
    logic                  r_ack;
    logic                  r_rty;

    // Line storage; deliberately outside the reset domain so contents survive RST.
    logic [127:0]          r_mem [DEPTH];

    logic                  w_req;
    logic                  w_in_idle;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_adr;
    logic [15:0]           w_sel;
    logic [127:0]          w_dat;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_go_resp;

    assign w_req     = bus.CYC & bus.STB;
    assign w_in_idle = (r_state == S_IDLE);

    // With LATENCY=1 the response edge is the acceptance edge itself, so the
    // live bus fields stand in for the not-yet-loaded capture registers.
    assign w_we  = w_in_idle ? bus.WE    : r_we;
    assign w_adr = w_in_idle ? bus.ADR   : r_adr;
    assign w_sel = w_in_idle ? bus.SEL   : r_sel;
    assign w_dat = w_in_idle ? bus.DAT_M : r_dat;

    assign w_in_range = (32'(w_adr) < 32'(DEPTH));
    assign w_idx      = w_adr[IDX_W-1:0];

    // The edge that enters RESP: counter reaches zero on this edge with the request still held.
    assign w_go_resp = w_req & ((w_in_idle & (LATENCY == 1)) |
                                ((r_state == S_WAIT) & (r_cnt == 8'd1)));

    // Transaction FSM with registered ACK/RTY/DAT_S and captured request fields.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_dat_s <= '0;
            r_ack   <= 1'b0;
            r_rty   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_rty <= 1'b0;
            if (w_go_resp) begin
                r_ack <= w_in_range;
                r_rty <= ~w_in_range;
                if (w_in_range && !w_we) begin
                    r_dat_s <= r_mem[w_idx];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_we  <= bus.WE;
                        r_adr <= bus.ADR;
                        r_sel <= bus.SEL;
                        r_dat <= bus.DAT_M;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LAT_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        // Abort: nothing committed, no response.
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // A request still held here is the old one; re-accept only from IDLE.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane masked line write, committed on the edge entering RESP.
    always_ff @(posedge CLK) begin
        if (w_go_resp && w_in_range && w_we) begin
            for (int i = 0; i < 16; i++) begin
                if (w_sel[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
                end
            end
        end
    end

    assign bus.DAT_S = r_dat_s;
    assign bus.ACK   = r_ack;
    assign bus.RTY   = r_rty;

endmodule

// File: tb/tb_wb_line_responder.sv
// Bench for wb_line_responder: two instances (full depth / LATENCY=4 and DEPTH=16 / LATENCY=1)
// share one set of request signals; dsel gates CYC/STB so only the selected one sees a request.
// Directed vector table, hand sequences for abort/reset/back-to-back, then randomized traffic.
module tb_wb_line_responder;

    localparam logic [127:0] D1     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] ALL_AA = {16{8'hAA}};
    localparam logic [127:0] ALL_55 = {16{8'h55}};
    localparam logic [127:0] MASKED = 128'hAAAAAAAA_AAAAAAAA_55555555_AAAAAAAA;
    localparam logic [127:0] C0     = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
    localparam logic [127:0] BF     = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] L3     = 128'h33333333_0000FFFF_12121212_A5A5A5A5;
    localparam logic [127:0] L4     = 128'h44444444_FFFF0000_34343434_5A5A5A5A;
    localparam logic [127:0] ALL_11 = {16{8'h11}};
    localparam logic [127:0] ALL_FF = {16{8'hFF}};

    logic         CLK = 1'b0;
    logic         RST;
    logic         cyc, stb, we;
    logic [11:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat_m;
    int           dsel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    wb_line_responder_if #(.ADDR_WIDTH(12)) ifa ();
    wb_line_responder_if #(.ADDR_WIDTH(12)) ifb ();

    assign ifa.CYC   = cyc && (dsel == 0);
    assign ifa.STB   = stb && (dsel == 0);
    assign ifa.WE    = we;
    assign ifa.ADR   = adr;
    assign ifa.SEL   = sel;
    assign ifa.DAT_M = dat_m;
    assign ifb.CYC   = cyc && (dsel == 1);
    assign ifb.STB   = stb && (dsel == 1);
    assign ifb.WE    = we;
    assign ifb.ADR   = adr;
    assign ifb.SEL   = sel;
    assign ifb.DAT_M = dat_m;

    wb_line_responder #(.ADDR_WIDTH(12), .DEPTH(4096), .LATENCY(4)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (ifa)
    );

    wb_line_responder #(.ADDR_WIDTH(12), .DEPTH(16), .LATENCY(1)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (ifb)
    );

    logic         cur_ack, cur_rty;
    logic [127:0] cur_dat;
    assign cur_ack = (dsel == 0) ? ifa.ACK   : ifb.ACK;
    assign cur_rty = (dsel == 0) ? ifa.RTY   : ifb.RTY;
    assign cur_dat = (dsel == 0) ? ifa.DAT_S : ifb.DAT_S;

    typedef struct {
        int           d;
        bit           w;
        logic [11:0]  a;
        logic [15:0]  s;
        logic [127:0] dm;
        bit           e_ack;
        bit           e_rty;
        logic [127:0] e_dat;
    } vec_t;

    vec_t tbl[14];

    // Reference state for the random phase: line contents and last read data per instance.
    logic [127:0] ma [32];
    logic [127:0] mb [16];
    logic [127:0] dsm [2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw,
                                           input logic [15:0] s);
        logic [127:0] r;
        r = old;
        for (int i = 0; i < 16; i++) begin
            if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One request: lat = edges counted from acceptance (1) to the edge starting the response cycle.
    task automatic do_txn(input int d, input bit w, input logic [11:0] a, input logic [15:0] s,
                          input logic [127:0] dm, input bit scramble,
                          output int lat, output bit ack, output bit rty, output logic [127:0] ds);
        @(negedge CLK);
        dsel = d; we = w; adr = a; sel = s; dat_m = dm; cyc = 1'b1; stb = 1'b1;
        lat = 0; ack = 1'b0; rty = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (cur_ack || cur_rty) begin
                lat = i; ack = cur_ack; rty = cur_rty;
                break;
            end
            if (scramble && i == 1) begin
                we = 1'($urandom); adr = 12'($urandom); sel = 16'($urandom); dat_m = rnd128();
            end
        end
        ds = cur_dat;
        @(negedge CLK);
        cyc = 1'b0; stb = 1'b0;
        @(posedge CLK); #1;
        chk("resp_single_cycle", {cur_ack, cur_rty}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        bit           ack, rty;
        logic [127:0] ds;
        bit           seen;
        int           n_ack, e1, e2;

        tbl[0]  = '{0, 1'b1, 12'h010, 16'hFFFF, D1,     1'b1, 1'b0, 128'h0};
        tbl[1]  = '{0, 1'b0, 12'h010, 16'h0000, 128'h0, 1'b1, 1'b0, D1};
        tbl[2]  = '{0, 1'b1, 12'h020, 16'hFFFF, ALL_AA, 1'b1, 1'b0, D1};
        tbl[3]  = '{0, 1'b1, 12'h020, 16'h00F0, ALL_55, 1'b1, 1'b0, D1};
        tbl[4]  = '{0, 1'b0, 12'h020, 16'h0000, 128'h0, 1'b1, 1'b0, MASKED};
        tbl[5]  = '{0, 1'b1, 12'h030, 16'hFFFF, C0,     1'b1, 1'b0, MASKED};
        tbl[6]  = '{0, 1'b1, 12'h030, 16'h0000, ALL_55, 1'b1, 1'b0, MASKED};
        tbl[7]  = '{0, 1'b0, 12'h030, 16'hFFFF, 128'h0, 1'b1, 1'b0, C0};
        tbl[8]  = '{1, 1'b1, 12'h00F, 16'hFFFF, BF,     1'b1, 1'b0, 128'h0};
        tbl[9]  = '{1, 1'b0, 12'h010, 16'h0000, 128'h0, 1'b0, 1'b1, 128'h0};
        tbl[10] = '{1, 1'b1, 12'h3FF, 16'hFFFF, ALL_55, 1'b0, 1'b1, 128'h0};
        tbl[11] = '{1, 1'b0, 12'h00F, 16'h0000, 128'h0, 1'b1, 1'b0, BF};
        tbl[12] = '{1, 1'b1, 12'h003, 16'hFFFF, L3,     1'b1, 1'b0, BF};
        tbl[13] = '{1, 1'b1, 12'h004, 16'hFFFF, L4,     1'b1, 1'b0, BF};

        RST = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_m = '0; dsel = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ack_a", ifa.ACK, 1'b0);
        chk("reset_rty_a", ifa.RTY, 1'b0);
        chk("reset_dat_a", ifa.DAT_S, 128'h0);
        chk("reset_dat_b", ifb.DAT_S, 128'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            do_txn(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].dm, 1'b1, lat, ack, rty, ds);
            chk($sformatf("vec%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_rty", i), rty, tbl[i].e_rty);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(tbl[i].d));
            chk($sformatf("vec%0d_dat_s", i), ds, tbl[i].e_dat);
        end

        // Abort: write of all 0xFF dropped after two cycles must leave line 0x005 alone.
        do_txn(0, 1'b1, 12'h005, 16'hFFFF, ALL_11, 1'b0, lat, ack, rty, ds);
        chk("abort_prewrite_ack", ack, 1'b1);
        @(negedge CLK);
        dsel = 0; we = 1'b1; adr = 12'h005; sel = 16'hFFFF; dat_m = ALL_FF; cyc = 1'b1; stb = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
            seen = seen | ifa.ACK | ifa.RTY;
        end
        @(negedge CLK);
        stb = 1'b0;
        repeat (6) begin
            @(posedge CLK); #1;
            seen = seen | ifa.ACK | ifa.RTY;
        end
        cyc = 1'b0;
        chk("abort_no_response", seen, 1'b0);
        chk("abort_dat_s_kept", ifa.DAT_S, C0);
        do_txn(0, 1'b0, 12'h005, 16'h0000, 128'h0, 1'b1, lat, ack, rty, ds);
        chk("abort_readback_ack", ack, 1'b1);
        chk("abort_readback_dat", ds, ALL_11);

        // Asynchronous reset two cycles into a read.
        @(negedge CLK);
        dsel = 0; we = 1'b0; adr = 12'h020; cyc = 1'b1; stb = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("midreset_ack", ifa.ACK, 1'b0);
        chk("midreset_rty", ifa.RTY, 1'b0);
        chk("midreset_dat_a", ifa.DAT_S, 128'h0);
        chk("midreset_dat_b", ifb.DAT_S, 128'h0);
        @(negedge CLK);
        cyc = 1'b0; stb = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        do_txn(0, 1'b0, 12'h010, 16'h0000, 128'h0, 1'b1, lat, ack, rty, ds);
        chk("postreset_ack", ack, 1'b1);
        chk("postreset_latency", lat, 4);
        chk("postreset_dat", ds, D1);

        // Back-to-back reads with CYC&STB held, LATENCY=1.
        @(negedge CLK);
        dsel = 1; we = 1'b0; adr = 12'h003; cyc = 1'b1; stb = 1'b1;
        n_ack = 0; e1 = 0; e2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (ifb.ACK) begin
                n_ack++;
                if (n_ack == 1) begin
                    e1 = i;
                    chk("b2b_first_dat", ifb.DAT_S, L3);
                    adr = 12'h004;
                end else begin
                    e2 = i;
                    chk("b2b_second_dat", ifb.DAT_S, L4);
                    break;
                end
            end
        end
        @(negedge CLK);
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_ack_count", n_ack, 2);
        chk("b2b_first_latency", e1, 1);
        chk("b2b_spacing", e2 - e1, 2);

        // Randomized traffic against the reference model.
        dsm[0] = D1;
        dsm[1] = L4;
        for (int i = 0; i < 32; i++) begin
            ma[i] = rnd128();
            do_txn(0, 1'b1, 12'(i), 16'hFFFF, ma[i], 1'b0, lat, ack, rty, ds);
            chk("preload_a_ack", ack, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            mb[i] = rnd128();
            do_txn(1, 1'b1, 12'(i), 16'hFFFF, mb[i], 1'b0, lat, ack, rty, ds);
            chk("preload_b_ack", ack, 1'b1);
        end
        for (int i = 0; i < 150; i++) begin
            int           d;
            bit           w, inr;
            int           a;
            logic [15:0]  s;
            logic [127:0] dm;
            int           r;
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom);
            a  = int'($urandom_range(0, 31));
            r  = int'($urandom_range(0, 3));
            s  = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
            dm = rnd128();
            inr = (d == 0) || (a < 16);
            do_txn(d, w, 12'(a), s, dm, 1'b1, lat, ack, rty, ds);
            if (inr) begin
                if (d == 0) begin
                    if (w) ma[a] = merge(ma[a], dm, s);
                    else   dsm[0] = ma[a];
                end else begin
                    if (w) mb[a] = merge(mb[a], dm, s);
                    else   dsm[1] = mb[a];
                end
            end
            chk($sformatf("rnd%0d_ack", i), ack, inr);
            chk($sformatf("rnd%0d_rty", i), rty, !inr);
            chk($sformatf("rnd%0d_latency", i), lat, exp_lat(d));
            chk($sformatf("rnd%0d_dat_s", i), ds, dsm[d]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
